// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-stream packet generator and the downstream
// packet counter: FSM state encoding plus beat/keep helper functions.
package axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } gen_state_e;

  // Widest byte-enable vector supported (DW = 1024).
  localparam int MAX_BPB = 128;

  // Byte-enable mask for a final beat holding r valid bytes; r == 0 means the
  // beat is completely full. Only the low bpb bits are meaningful.
  function automatic logic [MAX_BPB-1:0] keep_mask(input int r, input int bpb);
    logic [MAX_BPB-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BPB; i++) begin
      if ((i < bpb) && ((r == 0) || (i < r))) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  // Number of beats needed to carry a packet of the given byte length.
  function automatic logic [15:0] beats_for(input logic [15:0] bytes, input int bpb);
    int n;
    n = (int'({16'h0, bytes}) + bpb - 1) / bpb;
    return n[15:0];
  endfunction

endpackage

// File: rtl/axis_packet_gen.sv
// AXI-stream traffic source: on a start pulse emits a burst of equally sized
// packets, optionally separated by idle gaps. Every 32-bit lane of a beat
// carries {packet index, beat index}; disabled bytes are driven to zero.
module axis_packet_gen
  import axis_pkg::*;
#(
  parameter int DW = 512
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [15:0]     cfg_packet_count,
  input  logic [15:0]     cfg_packet_bytes,
  input  logic [7:0]      cfg_gap,
  output logic            busy,
  output logic            done,
  output logic [15:0]     packets_sent,
  output logic [DW-1:0]   axis_out_tdata,
  output logic [DW/8-1:0] axis_out_tkeep,
  output logic            axis_out_tlast,
  output logic            axis_out_tvalid,
  input  logic            axis_out_tready
);

  localparam int BPB = DW / 8;

  gen_state_e      state_q;
  logic [15:0]     count_q;
  logic [15:0]     bytes_q;
  logic [15:0]     beats_q;
  logic [7:0]      gap_q;
  logic [7:0]      gapCnt_q;
  logic [15:0]     pktIdx_q;
  logic [15:0]     beatIdx_q;
  logic [15:0]     sent_q;
  logic            busy_q;
  logic            done_q;
  logic [DW-1:0]   tdata_q;
  logic [BPB-1:0]  tkeep_q;
  logic            tlast_q;
  logic            tvalid_q;

  logic [15:0]     loadPkt_d;
  logic [15:0]     loadBeat_d;
  logic [15:0]     loadBeats_d;
  logic [15:0]     loadBytes_d;
  logic [15:0]     remBytes_d;
  logic            loadLast_d;
  logic [BPB-1:0]  loadKeep_d;
  logic [DW-1:0]   loadData_d;
  logic [31:0]     laneWord_d;
  logic            accept;
  logic            startOk;

  assign accept  = tvalid_q & axis_out_tready;
  assign startOk = start && (cfg_packet_count != 16'd0) && (cfg_packet_bytes != 16'd0);

  // Work out which beat would be presented next and build its contents, so
  // every output can be loaded straight into a register by the FSM.
  always_comb begin
    loadPkt_d   = pktIdx_q;
    loadBeat_d  = beatIdx_q + 16'd1;
    loadBeats_d = beats_q;
    loadBytes_d = bytes_q;
    case (state_q)
      ST_IDLE: begin
        loadPkt_d   = 16'd0;
        loadBeat_d  = 16'd0;
        loadBeats_d = beats_for(cfg_packet_bytes, BPB);
        loadBytes_d = cfg_packet_bytes;
      end
      ST_SEND: begin
        if (tlast_q) begin
          loadPkt_d  = pktIdx_q + 16'd1;
          loadBeat_d = 16'd0;
        end
      end
      ST_GAP: begin
        loadBeat_d = 16'd0;
      end
      default: begin
        loadBeat_d = 16'd0;
      end
    endcase
    remBytes_d = loadBytes_d % 16'(BPB);
    loadLast_d = (loadBeat_d == (loadBeats_d - 16'd1));
    laneWord_d = {loadPkt_d, loadBeat_d};
    loadKeep_d = '0;
    loadData_d = '0;
    for (int k = 0; k < BPB; k++) begin
      loadKeep_d[k] = !loadLast_d || (remBytes_d == 16'd0) || (16'(k) < remBytes_d);
      if (loadKeep_d[k]) begin
        loadData_d[8*k +: 8] = laneWord_d[8*(k%4) +: 8];
      end
    end
  end

  // Burst FSM with beat, packet and gap counters; all outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      bytes_q   <= '0;
      beats_q   <= '0;
      gap_q     <= '0;
      gapCnt_q  <= '0;
      pktIdx_q  <= '0;
      beatIdx_q <= '0;
      sent_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (startOk) begin
            count_q   <= cfg_packet_count;
            bytes_q   <= cfg_packet_bytes;
            beats_q   <= loadBeats_d;
            gap_q     <= cfg_gap;
            pktIdx_q  <= 16'd0;
            beatIdx_q <= 16'd0;
            sent_q    <= 16'd0;
            busy_q    <= 1'b1;
            tdata_q   <= loadData_d;
            tkeep_q   <= loadKeep_d;
            tlast_q   <= loadLast_d;
            tvalid_q  <= 1'b1;
            state_q   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (accept) begin
            if (tlast_q) begin
              sent_q <= sent_q + 16'd1;
              if (pktIdx_q == (count_q - 16'd1)) begin
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                tdata_q  <= '0;
                tkeep_q  <= '0;
                tlast_q  <= 1'b0;
                tvalid_q <= 1'b0;
                state_q  <= ST_IDLE;
              end else if (gap_q != 8'd0) begin
                pktIdx_q  <= loadPkt_d;
                beatIdx_q <= 16'd0;
                gapCnt_q  <= gap_q;
                tdata_q   <= '0;
                tkeep_q   <= '0;
                tlast_q   <= 1'b0;
                tvalid_q  <= 1'b0;
                state_q   <= ST_GAP;
              end else begin
                pktIdx_q  <= loadPkt_d;
                beatIdx_q <= 16'd0;
                tdata_q   <= loadData_d;
                tkeep_q   <= loadKeep_d;
                tlast_q   <= loadLast_d;
              end
            end else begin
              beatIdx_q <= loadBeat_d;
              tdata_q   <= loadData_d;
              tkeep_q   <= loadKeep_d;
              tlast_q   <= loadLast_d;
            end
          end
        end
        ST_GAP: begin
          gapCnt_q <= gapCnt_q - 8'd1;
          if (gapCnt_q == 8'd1) begin
            tdata_q  <= loadData_d;
            tkeep_q  <= loadKeep_d;
            tlast_q  <= loadLast_d;
            tvalid_q <= 1'b1;
            state_q  <= ST_SEND;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign packets_sent    = sent_q;
  assign axis_out_tdata  = tdata_q;
  assign axis_out_tkeep  = tkeep_q;
  assign axis_out_tlast  = tlast_q;
  assign axis_out_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_packet_gen.sv
// Self-checking bench for axis_packet_gen: a burst-level model expands each
// accepted start into the full list of expected beats; a per-cycle compare
// process checks every output against it.
module tb_axis_packet_gen;

  localparam int DW  = 512;
  localparam int BPB = DW / 8;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [BPB-1:0] keep;
    logic           last;
  } beat_t;

  logic            clk;
  logic            resetn;
  logic            start;
  logic [15:0]     cfgPacketCount;
  logic [15:0]     cfgPacketBytes;
  logic [7:0]      cfgGap;
  logic            busy;
  logic            done;
  logic [15:0]     packetsSent;
  logic [DW-1:0]   tdata;
  logic [BPB-1:0]  tkeep;
  logic            tlast;
  logic            tvalid;
  logic            tready;

  int    compared   = 0;
  int    mismatched = 0;
  beat_t expQ[$];
  beat_t gotQ[$];
  int    expGap     = 0;
  bit    gapPending = 0;
  int    idleCnt    = 0;
  bit    doneNext   = 0;
  int    sentModel  = 0;
  bit    checkEn    = 0;
  int    readyMode  = 0;
  bit    finalPop;

  axis_packet_gen #(.DW(DW)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .start            (start),
    .cfg_packet_count (cfgPacketCount),
    .cfg_packet_bytes (cfgPacketBytes),
    .cfg_gap          (cfgGap),
    .busy             (busy),
    .done             (done),
    .packets_sent     (packetsSent),
    .axis_out_tdata   (tdata),
    .axis_out_tkeep   (tkeep),
    .axis_out_tlast   (tlast),
    .axis_out_tvalid  (tvalid),
    .axis_out_tready  (tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream ready: held high, or toggled every cycle to exercise stalls.
  always @(posedge clk) begin
    #1;
    if (readyMode == 1) tready = ~tready;
    else                tready = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Expand a burst into its expected beats from byte counts alone.
  task automatic buildModel(input int bytes, input int count, input int gap);
    beat_t b;
    int remaining, n, beatNo;
    logic [31:0] word;
    expQ.delete();
    gotQ.delete();
    sentModel  = 0;
    expGap     = gap;
    gapPending = 0;
    for (int p = 0; p < count; p++) begin
      remaining = bytes;
      beatNo    = 0;
      while (remaining > 0) begin
        n      = (remaining > BPB) ? BPB : remaining;
        word   = (32'(p) << 16) | 32'(beatNo);
        b.data = '0;
        b.keep = '0;
        for (int k = 0; k < BPB; k++) begin
          if (k < n) begin
            b.keep[k]        = 1'b1;
            b.data[8*k +: 8] = 8'(word >> (8 * (k % 4)));
          end
        end
        b.last = (remaining == n);
        expQ.push_back(b);
        remaining -= n;
        beatNo++;
      end
    end
  endtask

  // Pulse start with a configuration; expectRun says whether it must launch a burst.
  task automatic applyStimulus(input int bytes, input int count, input int gap, input bit expectRun);
    @(posedge clk);
    #1;
    cfgPacketBytes = 16'(bytes);
    cfgPacketCount = 16'(count);
    cfgGap         = 8'(gap);
    start          = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (expectRun) buildModel(bytes, count, gap);
  endtask

  task automatic waitIdle(input int maxCycles);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL burst_timeout: got %0d beats outstanding, expected 0", expQ.size());
      expQ.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison against the model; sampled on the falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      finalPop = 0;
      checkOutput("busy", DW'(busy), DW'(expQ.size() != 0));
      checkOutput("done", DW'(done), DW'(doneNext));
      checkOutput("packets_sent", DW'(packetsSent), DW'(sentModel));
      if (tvalid) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_beat: got tvalid=1, expected tvalid=0");
        end else begin
          checkOutput("tdata", tdata, expQ[0].data);
          checkOutput("tkeep", DW'(tkeep), DW'(expQ[0].keep));
          checkOutput("tlast", DW'(tlast), DW'(expQ[0].last));
          if (gapPending) begin
            checkOutput("gap_cycles", DW'(idleCnt), DW'(expGap));
            gapPending = 0;
          end
          if (tready) begin
            gotQ.push_back({tdata, tkeep, tlast});
            if (expQ[0].last) begin
              sentModel++;
              if (expQ.size() == 1) finalPop = 1;
              else begin
                gapPending = 1;
                idleCnt    = 0;
              end
            end
            void'(expQ.pop_front());
          end
        end
      end else if (gapPending) begin
        idleCnt++;
      end
      doneNext = finalPop;
    end
  end

  initial begin
    resetn         = 1'b0;
    start          = 1'b0;
    cfgPacketCount = '0;
    cfgPacketBytes = '0;
    cfgGap         = '0;
    tready         = 1'b1;

    // Reset state
    #12;
    checkOutput("rst_tvalid", DW'(tvalid), '0);
    checkOutput("rst_busy", DW'(busy), '0);
    checkOutput("rst_done", DW'(done), '0);
    checkOutput("rst_packets_sent", DW'(packetsSent), '0);
    checkOutput("rst_tdata", tdata, '0);
    checkOutput("rst_tkeep", DW'(tkeep), '0);
    checkOutput("rst_tlast", DW'(tlast), '0);
    @(posedge clk);
    #1;
    resetn  = 1'b1;
    checkEn = 1;

    // 1: one full single-beat packet
    applyStimulus(64, 1, 0, 1);
    checkOutput("m1_beats", DW'(expQ.size()), DW'(1));
    checkOutput("m1_keep", DW'(expQ[0].keep), DW'({BPB{1'b1}}));
    waitIdle(100);
    checkOutput("t1_beats", DW'(gotQ.size()), DW'(1));
    checkOutput("t1_last", DW'(gotQ[0].last), DW'(1));
    checkOutput("t1_sent", DW'(packetsSent), DW'(1));

    // 2: two 130-byte packets back-to-back
    applyStimulus(130, 2, 0, 1);
    checkOutput("m2_beats", DW'(expQ.size()), DW'(6));
    checkOutput("m2_lane4", DW'(expQ[3].data[31:0]), DW'(32'h0001_0000));
    checkOutput("m2_keep6", DW'(expQ[5].keep), DW'(64'h3));
    checkOutput("m2_last3", DW'(expQ[2].last), DW'(1));
    waitIdle(100);
    checkOutput("t2_beats", DW'(gotQ.size()), DW'(6));
    checkOutput("t2_lane4", DW'(gotQ[3].data[31:0]), DW'(32'h0001_0000));
    checkOutput("t2_keep6", DW'(gotQ[5].keep), DW'(64'h3));
    checkOutput("t2_sent", DW'(packetsSent), DW'(2));

    // 3: same traffic with tready toggling every cycle
    readyMode = 1;
    applyStimulus(130, 2, 0, 1);
    waitIdle(200);
    readyMode = 0;
    checkOutput("t3_beats", DW'(gotQ.size()), DW'(6));
    checkOutput("t3_sent", DW'(packetsSent), DW'(2));

    // 4: idle gaps between packets
    applyStimulus(64, 3, 3, 1);
    waitIdle(100);
    checkOutput("t4_beats", DW'(gotQ.size()), DW'(3));
    checkOutput("t4_sent", DW'(packetsSent), DW'(3));

    // 5: zero-length and zero-count starts are ignored; start while busy ignored
    applyStimulus(0, 4, 0, 0);
    repeat (10) @(posedge clk);
    applyStimulus(64, 0, 0, 0);
    repeat (10) @(posedge clk);
    applyStimulus(200, 3, 2, 1);
    checkOutput("m5_keep4", DW'(expQ[3].keep), DW'(64'hFF));
    repeat (2) @(posedge clk);
    applyStimulus(64, 1, 0, 0);
    waitIdle(200);
    checkOutput("t5_beats", DW'(gotQ.size()), DW'(12));
    checkOutput("t5_sent", DW'(packetsSent), DW'(3));

    // 6: asynchronous reset in beat 2 of the second 130-byte packet
    applyStimulus(130, 2, 0, 1);
    begin
      int n;
      n = 0;
      while (expQ.size() != 2 && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
      checkOutput("t6_reached", DW'(expQ.size()), DW'(2));
    end
    #2;
    checkEn = 0;
    resetn  = 1'b0;
    #1;
    checkOutput("t6_tvalid", DW'(tvalid), '0);
    checkOutput("t6_busy", DW'(busy), '0);
    checkOutput("t6_sent", DW'(packetsSent), '0);
    expQ.delete();
    sentModel  = 0;
    doneNext   = 0;
    gapPending = 0;
    @(posedge clk);
    #1;
    resetn  = 1'b1;
    checkEn = 1;
    applyStimulus(130, 2, 0, 1);
    waitIdle(100);
    checkOutput("t6_after_beats", DW'(gotQ.size()), DW'(6));
    checkOutput("t6_after_sent", DW'(packetsSent), DW'(2));

    checkEn = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
